// File: rtl/bp_me_pkg.sv
// Shared types for the wormhole flit deserializer: FSM state enum and the flit-count helper macro.
`ifndef BP_ME_PKG_SV
`define BP_ME_PKG_SV

`define BP_ME_WH_NUM_FLITS(w, f) (((w) + (f) - 1) / (f))

package bp_me_pkg;

    typedef enum logic [1:0] {
        e_wh_idle = 2'd0,
        e_wh_body = 2'd1,
        e_wh_done = 2'd2
    } bp_me_wh_deser_state_e;

endpackage

`endif

// File: rtl/bp_me_wh_flit_counter.sv
// Body-flit index counter: clear has priority over load, load over increment.
module bp_me_wh_flit_counter #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (load_i) begin
            count_o <= load_val_i;
        end else if (up_i) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/bp_me_wormhole_flit_deserializer.sv
// Reassembles header+body wormhole flits into one packet {payload, len, cord} presented with v/yumi.
// Build option BP_ME_WH_DESER_PIPE_EN: accept the next header in the same cycle the packet is yumi'd.
module bp_me_wormhole_flit_deserializer
    import bp_me_pkg::*;
#(
    parameter int flit_width_p        = 64,
    parameter int cord_width_p        = 7,
    parameter int len_width_p         = 4,
    parameter int max_payload_width_p = 240,
    localparam int packet_width_lp    = cord_width_p + len_width_p + max_payload_width_p,
    localparam int max_flits_lp       = `BP_ME_WH_NUM_FLITS(packet_width_lp, flit_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [flit_width_p-1:0]    link_data_i,
    input  logic                       link_v_i,
    output logic                       link_ready_and_o,
    output logic [packet_width_lp-1:0] packet_o,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic                       len_err_o,
    output bp_me_wh_deser_state_e      state_o
);

    // Handshake: a flit transfers on any rising clk_i where link_v_i & link_ready_and_o;
    // a packet leaves on any rising clk_i where v_o & yumi_i (yumi_i only while v_o).

    bp_me_wh_deser_state_e  state_r;
    logic [len_width_p-1:0] len_r;
    logic [len_width_p-1:0] hdr_len;
    logic [len_width_p-1:0] count;
    logic                   len_err_r;
    logic                   ready_state;
    logic                   accept;
    logic                   hdr_accept;
    logic                   body_accept;
    logic                   body_last;

    always_comb begin
        ready_state = 1'b0;
        unique case (state_r)
            e_wh_idle, e_wh_body: ready_state = 1'b1;
`ifdef BP_ME_WH_DESER_PIPE_EN
            e_wh_done:            ready_state = yumi_i;
`else
            e_wh_done:            ready_state = 1'b0;
`endif
            default:              ready_state = 1'b0;
        endcase
    end

    assign link_ready_and_o = ready_state & reset_n_i;
    assign accept           = link_v_i & link_ready_and_o;
    // DONE only accepts when the pipelined build lets ready follow yumi_i.
    assign hdr_accept       = accept & ((state_r == e_wh_idle) | (state_r == e_wh_done));
    assign body_accept      = accept & (state_r == e_wh_body);
    assign hdr_len          = link_data_i[cord_width_p +: len_width_p];
    assign body_last        = (count == len_r);

    assign v_o       = (state_r == e_wh_done);
    assign len_err_o = len_err_r;
    assign state_o   = state_r;

    bp_me_wh_flit_counter #(
        .width_p (len_width_p)
    ) flit_counter (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .clear_i    (v_o & yumi_i & ~hdr_accept),
        .load_i     (hdr_accept),
        .load_val_i (len_width_p'(1)),
        .up_i       (body_accept & ~body_last),
        .count_o    (count)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_wh_idle;
            len_r     <= '0;
            len_err_r <= 1'b0;
        end else if (hdr_accept) begin
            len_r   <= hdr_len;
            state_r <= (hdr_len == '0) ? e_wh_done : e_wh_body;
            if (int'(hdr_len) > max_flits_lp - 1) begin
                len_err_r <= 1'b1;
            end
        end else begin
            unique case (state_r)
                e_wh_body: if (body_accept && body_last) state_r <= e_wh_done;
                e_wh_done: if (yumi_i) state_r <= e_wh_idle;
                default:   state_r <= state_r;
            endcase
        end
    end

    // Slot k holds flit k; the last slot is narrowed so bits beyond the packet never exist.
    for (genvar k = 0; k < max_flits_lp; k++) begin : g_slot
        localparam int lo_lp = k * flit_width_p;
        localparam int wd_lp = (packet_width_lp - lo_lp < flit_width_p) ?
                               (packet_width_lp - lo_lp) : flit_width_p;
        logic [wd_lp-1:0] slot_r;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                slot_r <= '0;
            end else if (hdr_accept) begin
                slot_r <= (k == 0) ? link_data_i[wd_lp-1:0] : '0;
            end else if (body_accept && (count == len_width_p'(k))) begin
                slot_r <= link_data_i[wd_lp-1:0];
            end
        end

        assign packet_o[lo_lp +: wd_lp] = slot_r;
    end

    always @(posedge clk_i) begin
        if (reset_n_i && yumi_i) begin
            assert (v_o) else $error("yumi_i asserted without v_o");
        end
    end

endmodule

// File: tb/tb_bp_me_wormhole_flit_deserializer.sv
// Directed and randomized bench for the wormhole flit deserializer against a queue-based packet model.
module tb_bp_me_wormhole_flit_deserializer;
    import bp_me_pkg::*;

    localparam int PW = 251;
`ifdef BP_ME_WH_DESER_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [63:0]           link_data = '0;
    logic                  link_v = 1'b0;
    logic                  yumi = 1'b0;
    logic                  ready;
    logic [PW-1:0]         packet;
    logic                  v;
    logic                  len_err;
    bp_me_wh_deser_state_e dbg_state;

    bp_me_wormhole_flit_deserializer dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .link_data_i      (link_data),
        .link_v_i         (link_v),
        .link_ready_and_o (ready),
        .packet_o         (packet),
        .v_o              (v),
        .yumi_i           (yumi),
        .len_err_o        (len_err),
        .state_o          (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: packets are lists of accepted flits; first flit's len says how many follow
    bit            m_have = 1'b0;
    bit            m_err = 1'b0;
    int            m_need = 0;
    logic [63:0]   m_flits[$];
    logic [PW-1:0] m_pkt = '0;
    logic [255:0]  m_acc;
    bit            m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have = 1'b0;
            m_err  = 1'b0;
            m_flits.delete();
            m_pkt  = '0;
        end else begin
            m_rdy = !m_have || (PIPE && yumi);
            if (m_have && yumi) m_have = 1'b0;
            if (link_v && m_rdy) begin
                if (m_flits.size() == 0) begin
                    m_need = int'(link_data[10:7]) + 1;
                    if (m_need > 4) m_err = 1'b1;
                end
                m_flits.push_back(link_data);
                if (m_flits.size() == m_need) begin
                    m_acc = '0;
                    for (int i = 0; i < m_flits.size() && i < 4; i++) m_acc[i*64 +: 64] = m_flits[i];
                    m_pkt  = m_acc[PW-1:0];
                    m_have = 1'b1;
                    m_flits.delete();
                end
            end
        end
    end

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("v_in_reset", v, 0);
            chk("ready_in_reset", ready, 0);
            chk("len_err_in_reset", len_err, 0);
        end else begin
            chk("v_o", v, m_have);
            chk("ready", ready, !m_have || (PIPE && yumi));
            chk("len_err", len_err, m_err);
            if (m_have) chk("packet", packet, m_pkt);
        end
    end

    // driver
    logic [63:0] send_q[$];
    int          v_pct = 100;
    int          yumi_pct = 0;
    int          n_fired = 0;
    bit          fire;

    task automatic step();
        @(negedge clk);
        fire = link_v && ready;
        @(posedge clk);
        #1;
        if (fire) begin
            void'(send_q.pop_front());
            n_fired++;
        end
        if (send_q.size() > 0 && $urandom_range(1, 100) <= v_pct) begin
            link_v    = 1'b1;
            link_data = send_q[0];
        end else begin
            link_v    = 1'b0;
            link_data = {$urandom(), $urandom()};
        end
        yumi = v && ($urandom_range(1, 100) <= yumi_pct);
    endtask

    task automatic wait_v(input string name);
        int c;
        for (c = 0; c < 60 && !v; c++) step();
        if (!v) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, v_o got 0 expected 1", name);
        end
    endtask

    task automatic take();
        yumi = 1'b1;
        step();
    endtask

    task automatic make_pkt(input int len, input logic [6:0] cord);
        logic [63:0] hdr;
        hdr = {$urandom(), $urandom()};
        hdr[10:7] = len[3:0];
        hdr[6:0]  = cord;
        send_q.push_back(hdr);
        for (int i = 0; i < len; i++) send_q.push_back({$urandom(), $urandom()});
    endtask

    logic [63:0]  h1, a, b, c, d, h3, h4, h5, h6;
    logic [63:0]  e[5];
    logic [255:0] t;
    int           base;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_packet", packet, 0);
        chk("reset_v", v, 0);
        chk("reset_ready", ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single-flit packet
        h1 = 64'h0123_4567_0001_0005;
        send_q.push_back(h1);
        wait_v("t1_wait");
        chk("t1_packet", packet, 256'(h1));
        take();

        // four back-to-back flits, len=3
        a = 64'hA5A5_A5A5_0000_0185;
        b = 64'h1111_2222_3333_4444;
        c = 64'h5555_6666_7777_8888;
        d = 64'hF9AB_CDEF_0246_8ACE;
        send_q.push_back(a);
        send_q.push_back(b);
        send_q.push_back(c);
        send_q.push_back(d);
        wait_v("t2_wait");
        t = {d, c, b, a};
        chk("t2_packet", packet, 256'(t[PW-1:0]));

        // hold while the next header waits on the link
        h3 = 64'hFFFF_0000_1234_0003;
        send_q.push_back(h3);
        repeat (5) step();
        chk("t3_ready_held", ready, PIPE && yumi);
        chk("t3_packet_held", packet, 256'(t[PW-1:0]));
        take();
        wait_v("t3_wait");
        chk("t3_next_packet", packet, 256'(h3));
        take();

        // len=5 overflows: six flits consumed, first four kept
        h4 = 64'h1111_2222_3333_0281;
        send_q.push_back(h4);
        for (int i = 0; i < 5; i++) begin
            e[i] = {32'hE000_0000 + i, $urandom()};
            send_q.push_back(e[i]);
        end
        wait_v("t4_wait");
        chk("t4_len_err", len_err, 1);
        t = {e[2], e[1], e[0], h4};
        chk("t4_packet", packet, 256'(t[PW-1:0]));
        take();
        send_q.push_back(64'h0000_0000_0000_0082);
        send_q.push_back(64'hCAFE_F00D_DEAD_BEEF);
        wait_v("t4_clean_wait");
        chk("t4_len_err_sticky", len_err, 1);
        take();

        // reset after two of four flits
        base = n_fired;
        make_pkt(3, 7'h11);
        for (int i = 0; i < 40 && n_fired < base + 2; i++) step();
        chk("t5_two_flits", n_fired - base, 2);
        rst_n = 1'b0;
        link_v = 1'b0;
        send_q.delete();
        yumi = 1'b0;
        step();
        chk("t5_v_reset", v, 0);
        chk("t5_ready_reset", ready, 0);
        step();
        rst_n = 1'b1;
        h5 = 64'h7777_8888_9999_0009;
        send_q.push_back(h5);
        wait_v("t5_wait");
        chk("t5_packet", packet, 256'(h5));
        chk("t5_len_err_cleared", len_err, 0);
        take();

`ifdef BP_ME_WH_DESER_PIPE_EN
        // yumi and new header in one cycle: no bubble
        send_q.push_back(64'h0000_0000_0000_0001);
        wait_v("t6_wait");
        h6 = 64'h6666_5555_4444_0002;
        send_q.push_back(h6);
        step();
        yumi = 1'b1;
        step();
        chk("t6_v_stays", v, 1);
        chk("t6_packet", packet, 256'(h6));
        take();
`else
        h6 = 64'h6666_5555_4444_0002;
        send_q.push_back(h6);
        wait_v("t6_wait");
        chk("t6_packet", packet, 256'(h6));
        take();
`endif

        // randomized traffic with back-pressure on both sides
        v_pct = 70;
        yumi_pct = 50;
        for (int p = 0; p < 60; p++) begin
            make_pkt(($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6),
                     7'($urandom_range(0, 127)));
        end
        for (int i = 0; i < 4000 && (send_q.size() > 0 || v); i++) step();
        chk("random_drained", send_q.size() + int'(v), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
